// File: rtl/sprite_anim_renderer.sv
// Scaled, mirrorable, multi-frame sprite fetch for the VGA pipeline.
// Scan position -> ROM address -> palette index/opaque, plus a tick-driven animation FSM.
module sprite_anim_renderer #(
  parameter int SPR_W           = 60,
  parameter int SPR_H           = 90,
  parameter int BOX_W           = 80,
  parameter int BOX_H           = 160,
  parameter int FRAMES          = 6,
  parameter int FRAME_TICKS     = 6,
  parameter int PIX_BITS        = 3,
  parameter int ADDR_W          = 15,
  parameter int TRANSPARENT_IDX = 0,
  parameter int V_ACTIVE        = 480
) (
  input  logic                      vga_clk,
  input  logic                      Reset,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  input  logic [9:0]                pos_x,
  input  logic [9:0]                pos_y,
  input  logic                      mirror,
  input  logic                      anim_start,
  input  logic                      loop,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [PIX_BITS-1:0]       rom_q,
  output logic [PIX_BITS-1:0]       pix_idx,
  output logic                      pix_opaque,
  output logic [$clog2(FRAMES)-1:0] frame_idx,
  output logic                      anim_busy,
  output logic                      anim_done,
  output logic [1:0]                dbg_state_o
);

  localparam int CW       = $clog2(SPR_W + 1);
  localparam int CFW      = $clog2(BOX_W + SPR_W);
  localparam int RFW      = $clog2(BOX_H + SPR_H);
  localparam int FIW      = $clog2(FRAMES);
  localparam int TW       = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int FRAME_SZ = SPR_W * SPR_H;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Position/mirror latched once per video frame at the tick
  logic [9:0] lpx_q, lpy_q;
  logic       lmirror_q;
  logic       tick;

  assign tick = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      lpx_q     <= '0;
      lpy_q     <= '0;
      lmirror_q <= 1'b0;
    end else if (tick) begin
      lpx_q     <= pos_x;
      lpy_q     <= pos_y;
      lmirror_q <= mirror;
    end
  end

  logic [10:0] x11, y11, lx11, ly11;
  logic        in_box;

  assign x11    = {1'b0, DrawX};
  assign y11    = {1'b0, DrawY};
  assign lx11   = {1'b0, lpx_q};
  assign ly11   = {1'b0, lpy_q};
  assign in_box = (x11 >= lx11) && (x11 < lx11 + 11'(BOX_W)) &&
                  (y11 >= ly11) && (y11 < ly11 + 11'(BOX_H));

  // Texel stepping: fractional accumulators replace the scale multiply/divide
  logic [CW-1:0]     col_q, col_d, cur_col, col_eff;
  logic [CFW-1:0]    cfrac_q, cfrac_d, cur_cfrac, csum;
  logic [ADDR_W-1:0] rbase_q, rbase_line, cur_rbase;
  logic [RFW-1:0]    rfrac_q, rfrac_line, rsum;
  logic [ADDR_W-1:0] fbase_q, fbase_d;
  logic [ADDR_W-1:0] addr_c;

  always_comb begin
    cur_col   = (DrawX == lpx_q) ? '0 : col_q;
    cur_cfrac = (DrawX == lpx_q) ? '0 : cfrac_q;
    csum      = cur_cfrac + CFW'(SPR_W);
    col_d     = cur_col;
    cfrac_d   = csum;
    if (csum >= CFW'(BOX_W)) begin
      col_d   = cur_col + CW'(1);
      cfrac_d = csum - CFW'(BOX_W);
    end

    rsum       = rfrac_q + RFW'(SPR_H);
    rbase_line = rbase_q;
    rfrac_line = rsum;
    if (DrawY == lpy_q) begin
      rbase_line = '0;
      rfrac_line = '0;
    end else if (rsum >= RFW'(BOX_H)) begin
      rbase_line = rbase_q + ADDR_W'(SPR_W);
      rfrac_line = rsum - RFW'(BOX_H);
    end
    cur_rbase = (DrawX == 10'd0) ? rbase_line : rbase_q;

    col_eff = lmirror_q ? (CW'(SPR_W - 1) - cur_col) : cur_col;
    addr_c  = fbase_q + cur_rbase + ADDR_W'(col_eff);
  end

  logic [ADDR_W-1:0]   rom_addr_q;
  logic                vis1_q, vis2_q;
  logic [PIX_BITS-1:0] pix_idx_q;
  logic                pix_opq_q;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      col_q      <= '0;
      cfrac_q    <= '0;
      rbase_q    <= '0;
      rfrac_q    <= '0;
      rom_addr_q <= '0;
      vis1_q     <= 1'b0;
      vis2_q     <= 1'b0;
      pix_idx_q  <= '0;
      pix_opq_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      cfrac_q <= cfrac_d;
      if (DrawX == 10'd0) begin
        rbase_q <= rbase_line;
        rfrac_q <= rfrac_line;
      end
      if (in_box) rom_addr_q <= addr_c;
      // Visibility rides two stages to meet the ROM data
      vis1_q    <= in_box && blank;
      vis2_q    <= vis1_q;
      pix_idx_q <= rom_q;
      pix_opq_q <= vis2_q && (rom_q != PIX_BITS'(TRANSPARENT_IDX));
    end
  end

  state_t         state_q, state_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [FIW-1:0] frame_q, frame_d;
  logic           done_q, done_d;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      fbase_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      fbase_q <= fbase_d;
      done_q  <= done_d;
    end
  end

  // Start outranks a coincident tick, which is then not counted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    fbase_d = fbase_q;
    done_d  = 1'b0;
    if (anim_start) begin
      state_d = S_PLAY;
      cnt_d   = '0;
      frame_d = '0;
      fbase_d = '0;
    end else if (tick && (state_q == S_PLAY)) begin
      if (cnt_q == TW'(FRAME_TICKS - 1)) begin
        cnt_d = '0;
        if (frame_q == FIW'(FRAMES - 1)) begin
          if (loop) begin
            frame_d = '0;
            fbase_d = '0;
          end else begin
            state_d = S_HOLD;
            done_d  = 1'b1;
          end
        end else begin
          frame_d = frame_q + FIW'(1);
          fbase_d = fbase_q + ADDR_W'(FRAME_SZ);
        end
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  assign rom_address = rom_addr_q;
  assign pix_idx     = pix_idx_q;
  assign pix_opaque  = pix_opq_q;
  assign frame_idx   = frame_q;
  assign anim_busy   = (state_q == S_PLAY);
  assign anim_done   = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: compressed scan frames, arithmetic reference model,
// queue scoreboard drained by an independent monitor, plus directed probes.
module tb_sprite_anim_renderer;
  localparam int SPR_W = 60, SPR_H = 90, BOX_W = 80, BOX_H = 160;
  localparam int FRAMES = 6, FT = 6, AW = 15, PB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    draw_x, draw_y, pos_x, pos_y;
  logic          blank, mirror, anim_start, loop_i;
  logic [AW-1:0] rom_address;
  logic [PB-1:0] rom_q, pix_idx;
  logic          pix_opaque, anim_busy, anim_done;
  logic [2:0]    frame_idx;
  logic [1:0]    dbg_state;

  sprite_anim_renderer dut (
    .vga_clk(clk), .Reset(rst), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .mirror(mirror), .anim_start(anim_start), .loop(loop_i),
    .rom_address(rom_address), .rom_q(rom_q), .pix_idx(pix_idx), .pix_opaque(pix_opaque),
    .frame_idx(frame_idx), .anim_busy(anim_busy), .anim_done(anim_done), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / ROM ----------------
  always #5 clk = ~clk;

  function automatic logic [PB-1:0] rom_val(input int a);
    int v;
    v = (a * 5) ^ (a >> 3);
    return v[PB-1:0];
  endfunction

  always @(posedge clk) rom_q <= rom_val(int'(rom_address));

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_fail = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [3:0]    exp_q[$];
  logic [4:0]    exp_fsm_q[$];
  int dut_done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_lx = 0, m_ly = 0, m_n = 0, m_addr = 0, done_cnt = 0;
  bit m_mir = 0, m_started = 0, m_loop = 0;

  function automatic bit m_busy();
    return m_started && (m_loop || m_n < FT * FRAMES);
  endfunction

  function automatic int m_frame();
    if (!m_started) return 0;
    if (m_loop) return (m_n / FT) % FRAMES;
    return (m_n / FT >= FRAMES - 1) ? FRAMES - 1 : m_n / FT;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input int x, input int y, input bit b, input bit st);
    bit in, tick, done;
    int col, row;
    logic [PB-1:0] v;
    @(negedge clk);
    draw_x = 10'(x); draw_y = 10'(y); blank = b; anim_start = st;
    in = (x >= m_lx) && (x < m_lx + BOX_W) && (y >= m_ly) && (y < m_ly + BOX_H);
    if (in) begin
      col = ((x - m_lx) * SPR_W) / BOX_W;
      row = ((y - m_ly) * SPR_H) / BOX_H;
      if (m_mir) col = SPR_W - 1 - col;
      m_addr = m_frame() * SPR_W * SPR_H + row * SPR_W + col;
    end
    v = rom_val(m_addr);
    exp_addr_q.push_back(AW'(m_addr));
    exp_q.push_back({in && b && (v != 0), v});
    tick = (x == 0) && (y == 480);
    done = 0;
    if (tick) begin
      m_lx = int'(pos_x); m_ly = int'(pos_y); m_mir = mirror;
    end
    if (st) begin
      m_started = 1; m_n = 0; m_loop = loop_i;
    end else if (tick && m_busy()) begin
      m_n++;
      if (!m_loop && m_n == FT * FRAMES) done = 1;
    end
    if (done) done_cnt++;
    exp_fsm_q.push_back({done, m_busy(), 3'(m_frame())});
  endtask

  task automatic goto_line(input int from, input int to);
    for (int y = from; y < to; y++) cycle(0, y, 1'b1, 1'b0);
  endtask

  task automatic short_frame(input bit st);
    cycle(0, 480, 1'b0, st);
    cycle(0, 0, 1'b0, 1'b0);
  endtask

  int pk_q[$], pe_q[$];

  // Drive a full line; check rom_address at box offsets pk_q; optional lone blank pixel
  task automatic probe_line(input int y, input int blank_k);
    bit b, need;
    for (int x = 0; x <= m_lx + BOX_W + 1; x++) begin
      b = (blank_k < 0) ? 1'b1 : (x == m_lx + blank_k);
      cycle(x, y, b, 1'b0);
      need = 0;
      foreach (pk_q[j]) if (x == m_lx + pk_q[j]) need = 1;
      if (blank_k >= 0 && x > m_lx + blank_k && x <= m_lx + blank_k + 3) need = 1;
      if (need) begin
        @(posedge clk); #1;
        foreach (pk_q[j])
          if (x == m_lx + pk_q[j])
            check($sformatf("addr_y%0d_k%0d", y, pk_q[j]), 32'(rom_address), 32'(pe_q[j]));
        if (blank_k >= 0 && x > m_lx + blank_k && x <= m_lx + blank_k + 3)
          check($sformatf("latency_opaque_k%0d", x - m_lx - 2), 32'(pix_opaque),
                32'(x == m_lx + blank_k + 2));
      end
    end
  endtask

  task automatic rnd_line(input int y);
    for (int x = 0; x <= m_lx + BOX_W + 1; x++) cycle(x, y, $urandom_range(0, 3) != 0, 1'b0);
  endtask

  task automatic full_frame(input bit st);
    int l0, l1, l2;
    cycle(0, 480, 1'b0, st);
    l0 = m_ly + int'($urandom_range(0, 40));
    l1 = m_ly + int'($urandom_range(41, 100));
    l2 = m_ly + int'($urandom_range(101, 159));
    goto_line(0, l0);      rnd_line(l0);
    goto_line(l0 + 1, l1); rnd_line(l1);
    goto_line(l1 + 1, l2); rnd_line(l2);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rom_address"}, 32'(rom_address), 0);
    check({tag, "_pix_idx"}, 32'(pix_idx), 0);
    check({tag, "_pix_opaque"}, 32'(pix_opaque), 0);
    check({tag, "_frame_idx"}, 32'(frame_idx), 0);
    check({tag, "_anim_busy"}, 32'(anim_busy), 0);
    check({tag, "_anim_done"}, 32'(anim_done), 0);
    check({tag, "_state_idle"}, 32'(dbg_state), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    reset_checks("midplay_reset");
    exp_addr_q.delete(); exp_q.delete(); exp_fsm_q.delete();
    m_lx = 0; m_ly = 0; m_mir = 0; m_n = 0; m_started = 0; m_addr = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [AW-1:0] ea;
    logic [3:0]    ep;
    logic [4:0]    ef;
    #1;
    if (!rst) begin
      if (anim_done) dut_done_cnt++;
      if (exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        check("rom_address", 32'(rom_address), 32'(ea));
      end
      if (exp_q.size() >= 3) begin
        ep = exp_q.pop_front();
        check("pix_idx", 32'(pix_idx), 32'(ep[2:0]));
        check("pix_opaque", 32'(pix_opaque), 32'(ep[3]));
      end
      if (exp_fsm_q.size() > 0) begin
        ef = exp_fsm_q.pop_front();
        check("frame_idx", 32'(frame_idx), 32'(ef[2:0]));
        check("anim_busy", 32'(anim_busy), 32'(ef[3]));
        check("anim_done", 32'(anim_done), 32'(ef[4]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit st;
    rst = 1'b1; draw_x = '0; draw_y = '0; blank = 1'b0; pos_x = '0; pos_y = '0;
    mirror = 1'b0; anim_start = 1'b0; loop_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_checks("por");
    @(posedge clk); #2 rst = 1'b0;

    // Scaling at (100,50), frame 0, with a lone-blank latency pixel on line 52
    pos_x = 10'd100; pos_y = 10'd50; mirror = 1'b0;
    cycle(0, 480, 1'b0, 1'b0);
    goto_line(0, 50);
    pk_q = '{0, 1, 2, 3, 79}; pe_q = '{0, 0, 1, 2, 59};
    probe_line(50, -1);
    cycle(0, 51, 1'b1, 1'b0);
    pk_q = '{0}; pe_q = '{60};
    probe_line(52, 40);
    goto_line(53, 209);
    pe_q = '{5340};
    probe_line(209, -1);

    // Mirror latched at tick; a mid-frame change must not take effect
    mirror = 1'b1;
    cycle(0, 480, 1'b0, 1'b0);
    goto_line(0, 50);
    pk_q = '{0, 79}; pe_q = '{59, 0};
    probe_line(50, -1);
    mirror = 1'b0;
    cycle(0, 51, 1'b1, 1'b0);
    pk_q = '{0}; pe_q = '{119};
    probe_line(52, -1);

    // Non-looping animation
    loop_i = 1'b0;
    cycle(0, 10, 1'b1, 1'b1);
    repeat (30) short_frame(1'b0);
    check("frame_after_30_ticks", 32'(frame_idx), 5);
    check("busy_after_30_ticks", 32'(anim_busy), 1);
    cycle(0, 480, 1'b0, 1'b0);
    goto_line(0, 50);
    pk_q = '{0}; pe_q = '{27000};
    probe_line(50, -1);
    repeat (5) short_frame(1'b0);
    check("hold_busy", 32'(anim_busy), 0);
    check("hold_frame", 32'(frame_idx), 5);
    check("done_pulses_first_run", 32'(dut_done_cnt), 1);
    repeat (3) short_frame(1'b0);
    check("done_pulses_in_hold", 32'(dut_done_cnt), 1);

    // Start from HOLD, looping
    loop_i = 1'b1;
    cycle(0, 20, 1'b1, 1'b1);
    cycle(0, 21, 1'b1, 1'b0);
    check("start_from_hold_busy", 32'(anim_busy), 1);
    check("start_from_hold_frame", 32'(frame_idx), 0);
    repeat (36) short_frame(1'b0);
    check("loop_wrap_frame", 32'(frame_idx), 0);
    check("loop_wrap_busy", 32'(anim_busy), 1);
    repeat (8) short_frame(1'b0);
    check("loop_frame_44", 32'(frame_idx), 1);

    // Start coincident with a tick: tick not counted
    short_frame(1'b1);
    check("coincident_start_frame", 32'(frame_idx), 0);
    repeat (5) short_frame(1'b0);
    check("coincident_5_ticks", 32'(frame_idx), 0);
    short_frame(1'b0);
    check("coincident_6_ticks", 32'(frame_idx), 1);

    // Reset in the middle of PLAY at frame 3
    loop_i = 1'b0;
    cycle(0, 30, 1'b1, 1'b1);
    repeat (18) short_frame(1'b0);
    check("frame_before_reset", 32'(frame_idx), 3);
    do_reset();

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      pos_x = 10'($urandom_range(0, 700));
      pos_y = 10'($urandom_range(1, 300));
      mirror = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 2) == 0);
      if (st) loop_i = 1'($urandom_range(0, 1));
      full_frame(st);
      repeat ($urandom_range(0, 10)) short_frame(1'b0);
    end
    repeat (4) cycle(0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("total_done_pulses", 32'(dut_done_cnt), 32'(done_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
